ssd_scan_driver: RTL

//  Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits sharing one segment bus.

---
 rtl/ssd_scan_driver.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver with a double-buffered hex word,
// internal 0-F decode, leading-zero blanking and PWM brightness.
module ssd_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000,
    parameter int DIM_BITS   = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   data_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      blank_lz,
    input  logic [DIM_BITS-1:0]       brightness,
    output logic [6:0]                seg_n,
    output logic                      dp_n,
    output logic [NUM_DIGITS-1:0]     digit_en_n,
    output logic                      frame_done,
    output logic                      pending
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]          cnt;
    logic [IDX_W-1:0]          idx;
    logic [DIM_BITS-1:0]       pwm_cnt;

    logic [4*NUM_DIGITS-1:0]   act_data;
    logic [NUM_DIGITS-1:0]     act_dp;
    logic                      act_blank;
    logic [DIM_BITS-1:0]       act_bright;

    logic [4*NUM_DIGITS-1:0]   pend_data;
    logic [NUM_DIGITS-1:0]     pend_dp;
    logic                      pend_blank;
    logic [DIM_BITS-1:0]       pend_bright;

    logic                      tick;
    logic                      boundary;
    logic                      zero_run;
    logic [NUM_DIGITS-1:0]     blank_vec;
    logic [3:0]                cur_nib;
    logic                      cur_dp;
    logic                      cur_blank;
    logic [6:0]                dec_seg;
    logic                      show;
    logic [6:0]                seg_next;
    logic                      dp_next;
    logic [NUM_DIGITS-1:0]     en_next;

    assign tick     = (cnt == CNT_LAST);
    assign boundary = tick && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt     <= '0;
            idx     <= '0;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (tick) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Active buffer only moves at the frame boundary; a load on that same edge stays pending.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            act_data    <= '0;
            act_dp      <= '0;
            act_blank   <= 1'b0;
            act_bright  <= '0;
            pend_data   <= '0;
            pend_dp     <= '0;
            pend_blank  <= 1'b0;
            pend_bright <= '0;
            pending     <= 1'b0;
        end else begin
            if (boundary && pending) begin
                act_data   <= pend_data;
                act_dp     <= pend_dp;
                act_blank  <= pend_blank;
                act_bright <= pend_bright;
            end
            if (load) begin
                pend_data   <= data_in;
                pend_dp     <= dp_in;
                pend_blank  <= blank_lz;
                pend_bright <= brightness;
                pending     <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end

    // A digit is blanked when it and every more significant nibble are zero.
    always_comb begin
        zero_run  = 1'b1;
        blank_vec = '0;
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (act_data[4*i +: 4] == 4'h0);
            if (i != 0) begin
                blank_vec[i] = act_blank && zero_run;
            end
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib   = act_data[4*i +: 4];
                cur_dp    = act_dp[i];
                cur_blank = blank_vec[i];
            end
        end
    end

    always_comb begin
        case (cur_nib)
            4'h0:    dec_seg = 7'h40;
            4'h1:    dec_seg = 7'h79;
            4'h2:    dec_seg = 7'h24;
            4'h3:    dec_seg = 7'h30;
            4'h4:    dec_seg = 7'h19;
            4'h5:    dec_seg = 7'h12;
            4'h6:    dec_seg = 7'h02;
            4'h7:    dec_seg = 7'h78;
            4'h8:    dec_seg = 7'h00;
            4'h9:    dec_seg = 7'h10;
            4'hA:    dec_seg = 7'h08;
            4'hB:    dec_seg = 7'h03;
            4'hC:    dec_seg = 7'h46;
            4'hD:    dec_seg = 7'h21;
            4'hE:    dec_seg = 7'h06;
            default: dec_seg = 7'h0E;
        endcase
    end

    // The first cycle of every slot is forced dark so the previous digit cannot ghost.
    always_comb begin
        show     = (pwm_cnt < act_bright) && (cnt != '0);
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        en_next  = '1;
        if (show) begin
            en_next  = ~(NUM_DIGITS'(1) << idx);
            seg_next = cur_blank ? 7'h7F : dec_seg;
            dp_next  = ~cur_dp;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            digit_en_n <= '1;
            frame_done <= 1'b0;
        end else begin
            seg_n      <= seg_next;
            dp_n       <= dp_next;
            digit_en_n <= en_next;
            frame_done <= boundary;
        end
    end

endmodule
